// File: rtl/mmu_pkg.sv
// mmu shared definitions: widths, page-table entry layout, fault causes, FSM states.
// MMU_WP_EN enables write-protect checking in mmu.
package mmu_pkg;

  localparam int VA_W      = 16;
  localparam int PAGE_BITS = 5;
  localparam int PFN_W     = 8;
  localparam int OFF_W     = VA_W - PAGE_BITS;
  localparam int PA_W      = PFN_W + OFF_W;
  localparam int ENT_W     = 11;
  localparam int N_ENT     = 1 << PAGE_BITS;

  localparam int PFN_LSB   = 0;
  localparam int PFN_MSB   = 7;
  localparam int VALID_BIT = 8;
  localparam int WR_BIT    = 9;
  localparam int USER_BIT  = 10;

  typedef enum logic [1:0] {
    CAUSE_INVALID = 2'd0,
    CAUSE_WP      = 2'd1,
    CAUSE_USER    = 2'd2,
    CAUSE_BUSY    = 2'd3
  } cause_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/mmu_page_table.sv
// 32-entry page table: one write port, valid-clear port,
// combinational lookup and registered readback.
module mmu_page_table
  import mmu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [PAGE_BITS-1:0] widx_i,
  input  logic [ENT_W-1:0]     wdata_i,
  input  logic                 clr_i,
  input  logic [PAGE_BITS-1:0] cidx_i,
  input  logic [PAGE_BITS-1:0] lidx_i,
  output logic [ENT_W-1:0]     ldata_o,
  input  logic [PAGE_BITS-1:0] ridx_i,
  output logic [ENT_W-1:0]     rdata_o
);

  logic [ENT_W-1:0] ent_q [N_ENT];
  logic [ENT_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) ent_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= ent_q[ridx_i];
      if (we_i) ent_q[widx_i] <= wdata_i;
      if (clr_i) ent_q[cidx_i][VALID_BIT] <= 1'b0;
    end
  end

  assign ldata_o = ent_q[lidx_i];
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mmu.sv
// Paging unit: VA->PA translation, rights checks, sticky fault, table flush.
// Build option MMU_WP_EN enables write-protect faults.
module mmu
  import mmu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VA_W-1:0]      cpu_addr,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic                 paging_en,
  input  logic                 user_mode,
  input  logic                 pt_we,
  input  logic [PAGE_BITS-1:0] pt_idx,
  input  logic [15:0]          pt_wdata,
  output logic [15:0]          pt_rdata,
  input  logic                 flush,
  output logic                 busy,
  output logic [PA_W-1:0]      mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 page_fault,
  output logic [VA_W-1:0]      fault_vaddr,
  output logic [1:0]           fault_cause,
  input  logic                 fault_clr
);

  state_e               state_q;
  logic [PAGE_BITS-1:0] cnt_q;
  logic                 busy_q;

  logic [ENT_W-1:0]     entry;
  logic [ENT_W-1:0]     rdata;
  logic                 req;
  logic                 wp_hit;
  logic                 flt;
  cause_e               cause;

  logic [PA_W-1:0]      mem_addr_q;
  logic                 mem_re_q;
  logic                 mem_we_q;
  logic                 fault_q;
  logic [VA_W-1:0]      vaddr_q;
  logic [1:0]           cause_q;

  mmu_page_table u_pt (
    .clk     (clk),
    .reset   (reset),
    .we_i    (pt_we & (state_q == IDLE)),
    .widx_i  (pt_idx),
    .wdata_i (pt_wdata[ENT_W-1:0]),
    .clr_i   (state_q == FLUSH),
    .cidx_i  (cnt_q),
    .lidx_i  (cpu_addr[VA_W-1:OFF_W]),
    .ldata_o (entry),
    .ridx_i  (pt_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == 5'd31) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req = cpu_re | cpu_we;

`ifdef MMU_WP_EN
  assign wp_hit = cpu_we & ~entry[WR_BIT];
`else
  assign wp_hit = 1'b0;
`endif

  // Conditions overlap, so the first true one wins.
  always_comb begin
    flt   = 1'b1;
    cause = CAUSE_INVALID;
    priority case (1'b1)
      (state_q == FLUSH):            cause = CAUSE_BUSY;
      !entry[VALID_BIT]:             cause = CAUSE_INVALID;
      (user_mode & ~entry[USER_BIT]): cause = CAUSE_USER;
      wp_hit:                        cause = CAUSE_WP;
      default:                       flt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      fault_q    <= 1'b0;
      vaddr_q    <= '0;
      cause_q    <= '0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (fault_clr) fault_q <= 1'b0;
      if (req && !fault_q) begin
        if (!paging_en) begin
          mem_addr_q <= {{(PA_W-VA_W){1'b0}}, cpu_addr};
          mem_re_q   <= ~cpu_we;
          mem_we_q   <= cpu_we;
        end else if (flt) begin
          fault_q <= 1'b1;
          vaddr_q <= cpu_addr;
          cause_q <= cause;
        end else begin
          mem_addr_q <= {entry[PFN_MSB:PFN_LSB], cpu_addr[OFF_W-1:0]};
          mem_re_q   <= ~cpu_we;
          mem_we_q   <= cpu_we;
        end
      end
    end
  end

  assign pt_rdata    = {{(16-ENT_W){1'b0}}, rdata};
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign page_fault  = fault_q;
  assign fault_vaddr = vaddr_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_mmu.sv
// Self-checking bench for mmu: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_mmu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_re, cpu_we, paging_en, user_mode;
  logic        pt_we;
  logic [4:0]  pt_idx;
  logic [15:0] pt_wdata;
  logic [15:0] pt_rdata;
  logic        flush, busy;
  logic [18:0] mem_addr;
  logic        mem_re, mem_we, page_fault;
  logic [15:0] fault_vaddr;
  logic [1:0]  fault_cause;
  logic        fault_clr;

  mmu dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_re(cpu_re),
    .cpu_we(cpu_we), .paging_en(paging_en), .user_mode(user_mode),
    .pt_we(pt_we), .pt_idx(pt_idx), .pt_wdata(pt_wdata),
    .pt_rdata(pt_rdata), .flush(flush), .busy(busy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .page_fault(page_fault), .fault_vaddr(fault_vaddr),
    .fault_cause(fault_cause), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  bit chk_en = 1'b0;

`ifdef MMU_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  // Model state
  logic [10:0] pt [32];
  int          fl_k;
  logic [18:0] m_addr;
  logic        m_re, m_we, m_fault, m_busy;
  logic [15:0] m_vaddr, m_rdata;
  logic [1:0]  m_cause;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [10:0] e;
    logic        flt, nf;
    logic [1:0]  c;
    if (reset) begin
      for (int i = 0; i < 32; i++) pt[i] = '0;
      fl_k = -1;
      m_addr = '0; m_re = 0; m_we = 0; m_fault = 0;
      m_vaddr = '0; m_cause = '0; m_rdata = '0; m_busy = 0;
      return;
    end
    m_re = 0;
    m_we = 0;
    e = pt[cpu_addr[15:11]];
    nf = m_fault && !fault_clr;
    if ((cpu_re || cpu_we) && !m_fault) begin
      if (!paging_en) begin
        m_addr = {3'b000, cpu_addr};
        m_we = cpu_we;
        m_re = !cpu_we;
      end else begin
        flt = 1;
        c = 0;
        if (fl_k >= 0) c = 3;
        else if (!e[8]) c = 0;
        else if (user_mode && !e[10]) c = 2;
        else if (WP && cpu_we && !e[9]) c = 1;
        else flt = 0;
        if (flt) begin
          nf = 1;
          m_vaddr = cpu_addr;
          m_cause = c;
        end else begin
          m_addr = {e[7:0], cpu_addr[10:0]};
          m_we = cpu_we;
          m_re = !cpu_we;
        end
      end
    end
    m_fault = nf;
    m_rdata = {5'b0, pt[pt_idx]};
    if (fl_k >= 0) begin
      pt[fl_k][8] = 1'b0;
      fl_k++;
      if (fl_k == 32) fl_k = -1;
    end else begin
      if (pt_we) pt[pt_idx] = pt_wdata[10:0];
      if (flush) fl_k = 0;
    end
    m_busy = (fl_k >= 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_re", 32'(mem_re), 32'(m_re));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("page_fault", 32'(page_fault), 32'(m_fault));
      chk("fault_vaddr", 32'(fault_vaddr), 32'(m_vaddr));
      chk("fault_cause", 32'(fault_cause), 32'(m_cause));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("pt_rdata", 32'(pt_rdata), 32'(m_rdata));
    end
  end

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; cpu_re = 0; cpu_we = 0; pt_we = 0;
    flush = 0; fault_clr = 0;
  endtask

  task automatic wr_pt(input logic [4:0] i, input logic [15:0] d);
    idle();
    pt_we = 1; pt_idx = i; pt_wdata = d;
    cyc();
    pt_we = 0;
  endtask

  task automatic access(input logic [15:0] a, input logic w);
    idle();
    cpu_addr = a; cpu_re = !w; cpu_we = w;
    cyc();
    cpu_re = 0; cpu_we = 0;
  endtask

  logic [10:0] fill [32];
  int n;

  initial begin
    idle();
    reset = 1; cpu_addr = 0; paging_en = 0; user_mode = 0;
    pt_idx = 0; pt_wdata = 0;
    chk_en = 1;
    cyc(); cyc();
    idle();
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(page_fault), 0);

    // Passthrough
    access(16'h1234, 0);
    chk("pass_addr", 32'(mem_addr), 32'h01234);
    chk("pass_re", 32'(mem_re), 1);

    // Translation
    wr_pt(5'd2, 16'h075A);
    paging_en = 1;
    access(16'h1456, 1);
    chk("xlat_addr", 32'(mem_addr), 32'h2D456);
    chk("xlat_we", 32'(mem_we), 1);

    // Invalid entry, suppression, clear
    access(16'hF800, 0);
    chk("inv_re", 32'(mem_re), 0);
    chk("inv_fault", 32'(page_fault), 1);
    chk("inv_vaddr", 32'(fault_vaddr), 32'hF800);
    chk("inv_cause", 32'(fault_cause), 0);
    access(16'h1456, 0);
    chk("supp_re", 32'(mem_re), 0);
    idle();
    fault_clr = 1; cpu_re = 1; cpu_addr = 16'h1456;
    cyc();
    idle();
    chk("clr_fault", 32'(page_fault), 0);
    chk("clr_supp_re", 32'(mem_re), 0);
    chk("clr_hold_vaddr", 32'(fault_vaddr), 32'hF800);
    access(16'h1456, 0);
    chk("after_clr_re", 32'(mem_re), 1);
    chk("after_clr_addr", 32'(mem_addr), 32'h2D456);

    // User violation
    wr_pt(5'd3, 16'h0111);
    user_mode = 1;
    access(16'h1800, 0);
    chk("user_cause", 32'(fault_cause), 2);
    user_mode = 0;
    idle(); fault_clr = 1; cyc(); idle();

    // Write to read-only entry
    wr_pt(5'd4, 16'h0522);
    access(16'h2000, 1);
`ifdef MMU_WP_EN
    chk("wp_cause", 32'(fault_cause), 1);
    chk("wp_fault", 32'(page_fault), 1);
`else
    chk("wp_we", 32'(mem_we), 1);
    chk("wp_addr", 32'(mem_addr), 32'h11000);
`endif
    idle(); fault_clr = 1; cyc(); idle();

    // Flush
    for (int i = 0; i < 32; i++) begin
      fill[i] = 11'h700 | 11'((i * 7 + 3) & 8'hFF);
      wr_pt(5'(i), {5'b0, fill[i]});
    end
    idle(); flush = 1; cyc(); idle();
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin cpu_re = 1; cpu_addr = 16'h1000; end
      else cpu_re = 0;
      cyc();
    end
    idle();
    chk("busy_len", 32'(n), 32);
    chk("busy_fault", 32'(page_fault), 1);
    chk("busy_cause", 32'(fault_cause), 3);
    fault_clr = 1; cyc(); idle();
    for (int i = 0; i < 32; i++) begin
      pt_idx = 5'(i);
      cyc();
      chk("flush_rb", 32'(pt_rdata), 32'(fill[i] & 11'h6FF));
    end

    // Reset mid-flush
    flush = 1; cyc(); idle();
    for (int i = 0; i < 10; i++) cyc();
    reset = 1; cyc(); idle();
    chk("mid_busy", 32'(busy), 0);
    chk("mid_addr", 32'(mem_addr), 0);
    chk("mid_fault", 32'(page_fault), 0);
    chk("mid_cause", 32'(fault_cause), 0);
    for (int i = 0; i < 32; i++) begin
      pt_idx = 5'(i);
      cyc();
      chk("mid_rb", 32'(pt_rdata), 0);
    end

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      reset     = ($urandom_range(0, 499) == 0);
      cpu_re    = 1'($urandom_range(0, 1));
      cpu_we    = ($urandom_range(0, 3) == 0);
      cpu_addr  = 16'($urandom);
      paging_en = ($urandom_range(0, 3) != 0);
      user_mode = ($urandom_range(0, 3) == 0);
      pt_we     = ($urandom_range(0, 2) == 0);
      pt_idx    = 5'($urandom);
      pt_wdata  = 16'($urandom);
      pt_wdata[8] = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      fault_clr = ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmu.md
# mmu

Paging unit between the CPU's memory port and physical RAM. It translates each 16-bit virtual address into a 19-bit physical address through a 32-entry page table held in registers. It checks access rights and raises a sticky `page_fault` level toward the interrupt encoder. Software fills the table through a register write port and can clear it with a multi-cycle flush.

## Interface
- `VA_W`, 16, virtual address width
- `PAGE_BITS`, 5, page-number bits; gives 32 entries and an 11-bit offset
- `PFN_W`, 8, physical frame number width; PA_W = PFN_W + 11 = 19
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cpu_addr`  in  16  virtual address
- `cpu_re` / `cpu_we`  in  1  read / write request strobes; `cpu_we` wins if both are high
- `paging_en`  in  1  translation enable (control register bit 2)
- `user_mode`  in  1  current access is user-mode
- `pt_we`  in  1  page-table entry write
- `pt_idx`  in  5  entry index for write and readback
- `pt_wdata`  in  16  entry: [7:0] pfn, [8] valid, [9] writable, [10] user; [15:11] ignored
- `pt_rdata`  out  16  registered readback of entry `pt_idx`
- `flush`  in  1  start clearing all valid bits
- `busy`  out  1  flush in progress
- `mem_addr`  out  19  physical address
- `mem_re` / `mem_we`  out  1  physical strobes
- `page_fault`  out  1  sticky fault level
- `fault_vaddr`  out  16  captured faulting virtual address
- `fault_cause`  out  2  0 invalid, 1 write-protect, 2 user violation, 3 busy
- `fault_clr`  in  1  clears `page_fault`

## Operation
- **Reset.** All entries are zeroed. All outputs go to 0. FSM goes to IDLE.
- **Request handling.** A request is any cycle with `cpu_re | cpu_we`.
- **Suppression.** While `page_fault`=1, requests are dropped: no strobes, no new capture.
- **`paging_en`=0.** `mem_addr = {3'b0, cpu_addr}`. Strobes pass through. No checks are made.
- **`paging_en`=1, entry lookup.** The entry is `cpu_addr[15:11]`. `mem_addr = {pfn, cpu_addr[10:0]}`.
- **Fault checks, in priority order:**
  1. FSM in FLUSH → cause 3.
  2. valid=0 → cause 0.
  3. `user_mode`=1 and user=0 → cause 2.
  4. Write with writable=0 → cause 1.
- **On a fault.** No strobe is issued. `page_fault`, `fault_vaddr` and `fault_cause` are set.
- **Clearing.** `fault_clr` clears `page_fault` only; `fault_vaddr` and `fault_cause` hold their values.
- **Same-cycle `pt_we` and request.** Translation uses the old entry contents (read-before-write).
- **`pt_we` during FLUSH.** Ignored.
- **FSM states.**
  - IDLE → FLUSH on `flush`. Accepted regardless of `page_fault`.
  - FLUSH: a 5-bit counter clears the valid bit of entry cnt each cycle, running 0→31.
  - FLUSH → IDLE after entry 31. The counter wraps to 0.
  - `flush` while in FLUSH is ignored.
- **Reset mid-flush.** FSM → IDLE, counter → 0, all entries zeroed.

## Timing
- Translation latency is 1 cycle. A request in cycle N produces registered `mem_addr`, `mem_re`, `mem_we` in cycle N+1.
- Strobes are single-cycle pulses per request cycle.
- `page_fault`, `fault_vaddr` and `fault_cause` are valid at N+1 for a faulting request at N.
- `fault_clr` at N → `page_fault`=0 at N+1. A request at N is still suppressed.
- `pt_we` at N → the new entry is used for requests from N+1 onward.
- `pt_rdata` shows entry `pt_idx` one cycle after it is presented.
- `flush` at N → `busy`=1 from N+1 through N+32. Entry k is cleared at edge N+1+k. `busy`=0 at N+33.
- `mem_addr` holds its last value when no strobe is issued.

## Configuration
- Macro: `MMU_WP_EN`.
- **Defined:** writes to entries with writable=0 fault with cause 1.
- **Undefined:** the writable bit is stored and read back but never checked, and cause 1 is never produced.

## Structure
- **Package `mmu_pkg`:**
  - entry field positions (PFN_LSB/MSB, VALID_BIT, WR_BIT, USER_BIT)
  - cause codes (CAUSE_INVALID, CAUSE_WP, CAUSE_USER, CAUSE_BUSY)
  - FSM state encoding (IDLE, FLUSH)
- **Sub-module `mmu_page_table`:**
  - 32×11-bit register array
  - one write port
  - a per-index valid-clear port for flush
  - a combinational lookup read port and a registered readback port
- Top level `mmu` holds the FSM, flush counter, checks, output pipeline register and fault latch.

## Test plan
- **Passthrough:** `paging_en`=0, read 0x1234 → next cycle `mem_addr`=0x01234, `mem_re`=1, `page_fault`=0.
- **Translation:** write entry 2 = pfn 0x5A, valid, writable, user; `paging_en`=1, write 0x1456 → `mem_addr`=0x2D456, `mem_we`=1.
- **Invalid entry:** read 0xF800 with entry 31 invalid → no strobe, `page_fault`=1, `fault_vaddr`=0xF800, `fault_cause`=0. A following read of 0x1456 is suppressed. `fault_clr` → `page_fault`=0 and the next read succeeds.
- **Rights checks:**
  - `user_mode`=1 read from a kernel-only entry → cause 2.
  - With `MMU_WP_EN`, write to a read-only entry → cause 1.
  - Without `MMU_WP_EN`, the same write succeeds.
- **Flush:** after filling all 32 entries, pulse `flush` → `busy` is high for exactly 32 cycles. A read during flush faults with cause 3. Afterward every entry reads back with valid=0 and the pfn intact.
- **Reset mid-flush:** reset at flush cycle 10 → `busy`=0, all outputs 0, all entries zero.
